// File: rtl/aes_round_sequencer.sv
// Sequencer and state register for an iterative AES encryption datapath.
// Walks the external round logic through AddRoundKey, Nr-1 full rounds and the final round.

module aes_round_sequencer_chk #(
    parameter int Nr    = 10,
    parameter int Nk    = 4,
    parameter int RND_W = 4
) (
    input logic              clk,
    input logic              rst_n,
    input logic              out_valid,
    input logic              out_ready,
    input logic [127:0]      out_data,
    input logic [RND_W-1:0]  round,
    input logic              in_ready,
    input logic              busy
);

    a_key_len: assert property (@(posedge clk) Nr == Nk + 6);

    a_out_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (out_valid && !out_ready) |=> $stable(out_data));

    a_round_max: assert property (@(posedge clk) disable iff (!rst_n)
        round <= RND_W'(Nr));

    a_ready_busy: assert property (@(posedge clk) disable iff (!rst_n)
        !(in_ready && busy));

endmodule

module aes_round_sequencer #(
    parameter int Nr    = 10,
    parameter int Nk    = 4,
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [128*(Nr+1)-1:0] word,
    input  logic                  key_valid,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [127:0]          in_data,
    output logic [127:0]          rd_state,
    output logic [127:0]          rd_key,
    output logic [1:0]            rd_mode,
    input  logic [127:0]          rd_result,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [127:0]          out_data,
    output logic                  busy,
    output logic [CNT_W-1:0]      blk_count
);

    localparam int KEY_W = 128 * (Nr + 1);
    localparam int RND_W = $clog2(Nr + 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FIRST = 3'd1,
        ROUND = 3'd2,
        FINAL = 3'd3,
        DONE  = 3'd4
    } fsm_t;

    fsm_t              fsm_r;
    fsm_t              fsm_nxt_s;
    logic [127:0]      state_r;
    logic [RND_W-1:0]  round_r;
    logic              out_valid_r;
    logic [CNT_W-1:0]  blk_count_r;
    logic              in_ready_s;
    logic              accept_s;
    logic [RND_W-1:0]  key_idx_s;
    logic [1:0]        rd_mode_s;
    logic              busy_s;
    logic [127:0]      key_arr_s [Nr+1];

    // Round r key sits r slices below the MSB of the expanded key bus.
    for (genvar g = 0; g <= Nr; g++) begin : g_key
        assign key_arr_s[g] = word[KEY_W-1-128*g -: 128];
    end

    assign in_ready_s = key_valid && ((fsm_r == IDLE) || ((fsm_r == DONE) && out_ready));
    assign accept_s   = in_valid && in_ready_s;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fsm_r <= IDLE;
        end else begin
            fsm_r <= fsm_nxt_s;
        end
    end

    // Next-state decode; every busy state stalls while the key is not usable
    always_comb begin
        fsm_nxt_s = fsm_r;
        case (fsm_r)
            IDLE:  if (accept_s) fsm_nxt_s = FIRST; else fsm_nxt_s = IDLE;
            FIRST: if (key_valid) fsm_nxt_s = (Nr == 1) ? FINAL : ROUND; else fsm_nxt_s = FIRST;
            ROUND: if (key_valid && (round_r == RND_W'(Nr - 1))) fsm_nxt_s = FINAL; else fsm_nxt_s = ROUND;
            FINAL: if (key_valid) fsm_nxt_s = DONE; else fsm_nxt_s = FINAL;
            DONE: begin
                if (out_ready) fsm_nxt_s = accept_s ? FIRST : IDLE;
                else           fsm_nxt_s = DONE;
            end
            default: fsm_nxt_s = IDLE;
        endcase
    end

    // Datapath control outputs decoded from the current state
    always_comb begin
        rd_mode_s = 2'd3;
        key_idx_s = '0;
        busy_s    = 1'b0;
        case (fsm_r)
            FIRST: begin rd_mode_s = 2'd0; key_idx_s = '0;            busy_s = 1'b1; end
            ROUND: begin rd_mode_s = 2'd1; key_idx_s = round_r;       busy_s = 1'b1; end
            FINAL: begin rd_mode_s = 2'd2; key_idx_s = RND_W'(Nr);    busy_s = 1'b1; end
            IDLE:  begin rd_mode_s = 2'd3; key_idx_s = '0;            busy_s = 1'b0; end
            DONE:  begin rd_mode_s = 2'd3; key_idx_s = '0;            busy_s = 1'b0; end
            default: begin rd_mode_s = 2'd3; key_idx_s = '0;          busy_s = 1'b0; end
        endcase
    end

    // State, round counter, output valid and hand-off counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= '0;
            round_r     <= '0;
            out_valid_r <= 1'b0;
            blk_count_r <= '0;
        end else begin
            case (fsm_r)
                IDLE: begin
                    if (accept_s) begin
                        state_r <= in_data;
                        round_r <= '0;
                    end
                end
                FIRST: begin
                    if (key_valid) begin
                        state_r <= rd_result;
                        round_r <= RND_W'(1);
                    end
                end
                ROUND: begin
                    if (key_valid) begin
                        state_r <= rd_result;
                        round_r <= round_r + RND_W'(1);
                    end
                end
                FINAL: begin
                    if (key_valid) begin
                        state_r     <= rd_result;
                        out_valid_r <= 1'b1;
                    end
                end
                DONE: begin
                    // A same-edge accept reloads the state so blocks run back to back.
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        blk_count_r <= blk_count_r + CNT_W'(1);
                        if (accept_s) begin
                            state_r <= in_data;
                            round_r <= '0;
                        end
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_s;
    assign rd_state  = state_r;
    assign rd_key    = key_arr_s[key_idx_s];
    assign rd_mode   = rd_mode_s;
    assign out_valid = out_valid_r;
    assign out_data  = state_r;
    assign busy      = busy_s;
    assign blk_count = blk_count_r;

    aes_round_sequencer_chk #(.Nr(Nr), .Nk(Nk), .RND_W(RND_W)) u_chk (
        .clk       (clk),
        .rst_n     (rst_n),
        .out_valid (out_valid_r),
        .out_ready (out_ready),
        .out_data  (state_r),
        .round     (round_r),
        .in_ready  (in_ready_s),
        .busy      (busy_s)
    );

endmodule

// File: doc/aes_round_sequencer.md
Name: aes_round_sequencer

Overview:
- Control and state-holding block for the iterative AES encryption datapath.
- Accepts one 128-bit plaintext block over a valid/ready handshake and owns the state register.
- Drives an external combinational round datapath once per cycle: initial AddRoundKey, Nr-1 full rounds, then the final round with no MixColumns. It selects the matching round key from the expanded key bus.
- Presents the ciphertext over a valid/ready handshake. Sits between the block source and the key-expansion/round logic.

Parameters:
- Nr, 10, number of rounds (10/12/14 for AES-128/192/256).
- Nk, 4, key length in 32-bit words. Informational only; must satisfy Nr == Nk+6.
- CNT_W, 16, width of the completed-block counter.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst_n  input  1  synchronous active-low reset.
- word  input  128*(Nr+1)  expanded key. Round r key is word[128*(Nr+1)-1-128*r -: 128], so round 0 is the MSB slice.
- key_valid  input  1  expanded key is stable and usable.
- in_valid  input  1  plaintext offered.
- in_ready  output  1  sequencer can accept a block.
- in_data  input  128  plaintext.
- rd_state  output  128  current state to the round datapath (= state register).
- rd_key  output  128  round key selected by the round counter.
- rd_mode  output  2  0 = AddRoundKey only, 1 = full round, 2 = final round, 3 = idle (datapath output ignored).
- rd_result  input  128  combinational datapath result for rd_state/rd_key/rd_mode.
- out_valid  output  1  ciphertext available.
- out_ready  input  1  consumer accepts ciphertext.
- out_data  output  128  ciphertext (= state register while out_valid).
- busy  output  1  high in FIRST, ROUND, FINAL.
- blk_count  output  CNT_W  number of blocks handed off on the output; wraps.

Behaviour:
- Reset (rst_n=0 at an edge): fsm=IDLE, state=0, round=0, out_valid=0, blk_count=0. Reset overrides any in-flight block, which is discarded. Combinational outputs follow from that state: in_ready=key_valid, rd_mode=3, busy=0.
- States: IDLE, FIRST, ROUND, FINAL, DONE.
- in_ready = key_valid && (fsm==IDLE || (fsm==DONE && out_ready)). Acceptance is in_valid && in_ready.
- IDLE: on accept, state<=in_data, round<=0, go to FIRST.
- FIRST: rd_mode=0, rd_key=key[0]. If key_valid, state<=rd_result, round<=1, go to ROUND. If Nr==1, go to FINAL instead.
- ROUND: rd_mode=1, rd_key=key[round]. If key_valid, state<=rd_result and round<=round+1. When round==Nr-1 at the edge, go to FINAL (round becomes Nr).
- FINAL: rd_mode=2, rd_key=key[Nr]. If key_valid, state<=rd_result, go to DONE, out_valid<=1.
- Stall: key_valid=0 in FIRST, ROUND or FINAL holds state, round and fsm unchanged. There is no timeout.
- DONE: out_data=state, held stable while out_valid && !out_ready.
  - out_ready=1 with no accept: out_valid<=0, blk_count++, go to IDLE.
  - out_ready=1 with accept on the same edge: blk_count++, state<=in_data, round<=0, go to FIRST, out_valid<=0. This gives back-to-back operation with no IDLE bubble.
- Latency: accept at edge E0 gives out_valid=1 after edge E0+Nr+1 (11 edges for Nr=10) with no stalls. Throughput is one block per Nr+2 cycles.
- rd_mode=3 and rd_key=key[0] in IDLE and DONE. rd_result is ignored there.
- blk_count wraps from 2^CNT_W-1 to 0.
- Assertions:
  - out_data stable while out_valid && !out_ready.
  - round never exceeds Nr.
  - in_ready never high while busy.

Test Plan:
- FIPS-197 App. B:
  - Stimulus: key 2b7e151628aed2a6abf7158809cf4f3c expanded by the bench model, plaintext 3243f6a8885a308d313198a2e0370734, bench AES round model on rd_*, out_ready=1.
  - Required: out_data=3925841d02dc09fbdc118597196a0b32, out_valid exactly 11 edges after accept, then blk_count=1.
- Round sequencing: log rd_mode/rd_key per cycle for one block -> sequence 0,1×9,2 with rd_key = key[0..10] in order.
- Backpressure and back-to-back:
  - Hold out_ready=0 for 5 cycles after out_valid -> out_data constant, in_ready=0.
  - Then raise out_ready with in_valid=1 and a second block (App. C.1 plaintext 00112233445566778899aabbccddeeff, key 000102…0f) -> same-edge handoff, second result 69c4e0d86a7b0430d8cdb78070b4c55a, blk_count=2.
- Key stall: drop key_valid for 3 cycles during round 4 -> state and round frozen, out_valid 14 edges after accept, ciphertext unchanged from the no-stall run.
- Reset mid-operation: assert rst_n=0 for one edge at round 6 -> out_valid=0, busy=0, blk_count=0 next cycle. A fresh block afterwards completes correctly.
- Gating and wrap:
  - key_valid=0 in IDLE -> in_ready=0, no accept.
  - With CNT_W=2, hand off 5 blocks -> blk_count=1.
